// File: rtl/automata_ctrl_pkg.sv
// Shared definitions for the automata stream controller: FSM encoding,
// report-entry layout and default parameter values.
package automata_ctrl_pkg;

  localparam int DEF_NUM_REPORTS = 28;
  localparam int DEF_SYM_W       = 8;
  localparam int DEF_OFF_W       = 32;
  localparam int DEF_FIFO_DEPTH  = 8;
  localparam int DEF_RPT_LAT     = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FLUSH  = 3'd4
  } state_e;

  // One queued report: offset in the upper bits, vector in the lower bits.
  typedef struct packed {
    logic [DEF_OFF_W-1:0]       offset;
    logic [DEF_NUM_REPORTS-1:0] vector;
  } rpt_entry_t;

endpackage

// File: rtl/automata_report_fifo.sv
// First-word-fall-through report FIFO; simultaneous push and pop both take
// effect, including a pop of the last entry while a new one is written.
module automata_report_fifo #(
  parameter int WIDTH = 60,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign free_cnt = CNT_W'(DEPTH) - count_q;

endmodule

// File: rtl/automata_stream_controller.sv
// Streams symbols into an automata stage and queues nonzero report vectors
// with their symbol offsets. Optional feature: AUTOMATA_REPORT_COUNT_EN adds rpt_count.
module automata_stream_controller
  import automata_ctrl_pkg::*;
#(
  parameter int NUM_REPORTS = DEF_NUM_REPORTS,
  parameter int SYM_W       = DEF_SYM_W,
  parameter int OFF_W       = DEF_OFF_W,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int RPT_LAT     = DEF_RPT_LAT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   sym_valid,
  output logic                   sym_ready,
  input  logic [SYM_W-1:0]       sym_data,
  input  logic                   sym_last,
  output logic                   stage_run,
  output logic                   stage_reset,
  output logic [SYM_W-1:0]       stage_symbols,
  input  logic [NUM_REPORTS-1:0] stage_reports,
  output logic                   rpt_valid,
  input  logic                   rpt_ready,
  output logic [OFF_W-1:0]       rpt_offset,
  output logic [NUM_REPORTS-1:0] rpt_vector,
  output logic                   busy,
  output logic                   done
`ifdef AUTOMATA_REPORT_COUNT_EN
  ,
  output logic [OFF_W-1:0]       rpt_count
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 3;
  localparam int ENT_W = OFF_W + NUM_REPORTS;
  localparam logic [RPT_LAT-1:0] TAIL_MASK = RPT_LAT'(1) << (RPT_LAT - 1);

  state_e               state_q, state_d;
  logic [OFF_W-1:0]     offset_q, offset_d;
  logic [SYM_W-1:0]     sym_hold_q, sym_hold_d;
  logic [RPT_LAT-1:0]   sr_vld_q, sr_vld_d;
  logic [OFF_W-1:0]     sr_off_q [RPT_LAT];
  logic [OFF_W-1:0]     sr_off_d [RPT_LAT];
  logic                 accept, space_ok, tail_vld, push, pop;
  logic                 fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_free;
  logic [SUM_W-1:0]     reserve;
  logic [ENT_W-1:0]     push_data, pop_data;

  // Slots still needed: entries already in the latency pipe plus RPT_LAT more.
  always_comb begin
    reserve = SUM_W'(RPT_LAT);
    for (int i = 0; i < RPT_LAT; i++) reserve = reserve + SUM_W'(sr_vld_q[i]);
    space_ok = SUM_W'(fifo_free) > reserve;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = ST_STREAM;
      ST_STREAM: if (accept && sym_last) state_d = ST_DRAIN;
      ST_DRAIN:  if ((sr_vld_q & ~TAIL_MASK) == '0) state_d = ST_FLUSH;
      ST_FLUSH:  if (fifo_empty) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sym_ready   = 1'b0;
    stage_reset = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    if (reset) begin
      stage_reset = 1'b1;
    end else begin
      busy = (state_q != ST_IDLE);
      case (state_q)
        ST_CLEAR:  stage_reset = 1'b1;
        ST_STREAM: sym_ready   = space_ok;
        ST_FLUSH:  done        = fifo_empty;
        default:   ;
      endcase
    end
  end

  assign accept        = sym_valid && sym_ready;
  assign stage_run     = accept;
  assign stage_symbols = reset ? '0 : (accept ? sym_data : sym_hold_q);

  always_comb begin
    offset_d   = offset_q;
    sym_hold_d = sym_hold_q;
    sr_vld_d   = '0;
    sr_off_d   = sr_off_q;
    if (state_q == ST_CLEAR) offset_d = '0;
    else if (accept)         offset_d = offset_q + OFF_W'(1);
    if (accept) sym_hold_d = sym_data;
    sr_vld_d[0] = accept;
    sr_off_d[0] = offset_q;
    for (int i = 1; i < RPT_LAT; i++) begin
      sr_vld_d[i] = sr_vld_q[i-1];
      sr_off_d[i] = sr_off_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      offset_q   <= '0;
      sym_hold_q <= '0;
      sr_vld_q   <= '0;
    end else begin
      offset_q   <= offset_d;
      sym_hold_q <= sym_hold_d;
      sr_vld_q   <= sr_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    sr_off_q <= sr_off_d;
  end

  // Pipe tail lines up with the stage's report output for that symbol.
  assign tail_vld  = sr_vld_q[RPT_LAT-1];
  assign rpt_valid = !reset && !fifo_empty;
  assign pop       = rpt_valid && rpt_ready;
  assign push      = !reset && tail_vld && (stage_reports != '0) && (!fifo_full || pop);
  assign push_data = {sr_off_q[RPT_LAT-1], stage_reports};

  automata_report_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .free_cnt  (fifo_free)
  );

  assign rpt_offset = pop_data[ENT_W-1 -: OFF_W];
  assign rpt_vector = pop_data[NUM_REPORTS-1:0];

`ifdef AUTOMATA_REPORT_COUNT_EN
  logic [OFF_W-1:0] rpt_count_q, rpt_count_d;

  function automatic logic [OFF_W-1:0] sat_inc(input logic [OFF_W-1:0] v);
    return (&v) ? v : v + OFF_W'(1);
  endfunction

  always_comb begin
    rpt_count_d = rpt_count_q;
    if (state_q == ST_CLEAR) rpt_count_d = '0;
    else if (push)           rpt_count_d = sat_inc(rpt_count_q);
  end

  always_ff @(posedge clk) begin
    if (reset) rpt_count_q <= '0;
    else       rpt_count_q <= rpt_count_d;
  end

  assign rpt_count = rpt_count_q;
`endif

endmodule

// File: tb/tb_automata_stream_controller.sv
// Directed bench for automata_stream_controller with a one-cycle-latency
// stage model whose report vector is looked up from the symbol.
module tb_automata_stream_controller;

  logic        clk;
  logic        reset, start, sym_valid, sym_last, rpt_ready;
  logic [7:0]  sym_data;
  logic        sym_ready, stage_run, stage_reset, rpt_valid, busy, done;
  logic [7:0]  stage_symbols;
  logic [27:0] stage_reports, rpt_vector;
  logic [31:0] rpt_offset;
`ifdef AUTOMATA_REPORT_COUNT_EN
  logic [31:0] rpt_count;
  logic [31:0] done_rpt_count;
`endif

  int errors = 0;
  int checks = 0;

  logic [27:0] rmap [256];
  logic        last_run;
  logic [7:0]  last_sym;
  int          cyc, run_cnt, done_cnt, clr_cnt, vld_cycles, done_cyc, lastacc_cyc;
  logic [59:0] pop_q [$];

  automata_stream_controller dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .sym_valid     (sym_valid),
    .sym_ready     (sym_ready),
    .sym_data      (sym_data),
    .sym_last      (sym_last),
    .stage_run     (stage_run),
    .stage_reset   (stage_reset),
    .stage_symbols (stage_symbols),
    .stage_reports (stage_reports),
    .rpt_valid     (rpt_valid),
    .rpt_ready     (rpt_ready),
    .rpt_offset    (rpt_offset),
    .rpt_vector    (rpt_vector),
    .busy          (busy),
    .done          (done)
`ifdef AUTOMATA_REPORT_COUNT_EN
    ,
    .rpt_count     (rpt_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stage model: report appears one cycle after the symbol was run.
  always @(posedge clk) begin
    last_run <= reset ? 1'b0 : stage_run;
    last_sym <= stage_symbols;
    cyc      <= cyc + 1;
  end
  assign stage_reports = last_run ? rmap[last_sym] : 28'h0;

  always @(negedge clk) begin
    if (!reset) begin
      if (stage_run) run_cnt <= run_cnt + 1;
      if (stage_run && sym_last) lastacc_cyc <= cyc;
      if (stage_reset) clr_cnt <= clr_cnt + 1;
      if (rpt_valid) vld_cycles <= vld_cycles + 1;
      if (rpt_valid && rpt_ready) pop_q.push_back({rpt_offset, rpt_vector});
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
`ifdef AUTOMATA_REPORT_COUNT_EN
        done_rpt_count <= rpt_count;
`endif
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stream(input int n, input logic [7:0] s0, input bit with_last);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 500) begin
      sym_valid = 1'b1;
      sym_data  = s0 + 8'(i);
      sym_last  = with_last && (i == n - 1);
      #1;
      if (sym_ready) i++;
      tick();
      guard++;
    end
    sym_valid = 1'b0;
    sym_last  = 1'b0;
    chk("stream_accepts", i, n);
  endtask

  task automatic wait_done();
    int d0;
    int g;
    d0 = done_cnt;
    g = 0;
    while (done_cnt == d0 && g < 300) begin
      tick();
      g++;
    end
    chk("done_seen", done_cnt - d0, 1);
  endtask

  int r0, c0, v0, d0;

  initial begin
    for (int i = 0; i < 256; i++) rmap[i] = 28'h0;
    cyc = 0; run_cnt = 0; done_cnt = 0; clr_cnt = 0; vld_cycles = 0;
    done_cyc = 0; lastacc_cyc = 0;
    reset = 1'b1; start = 1'b0; sym_valid = 1'b0; sym_last = 1'b0;
    sym_data = 8'h0; rpt_ready = 1'b1;

    // Reset values
    tick(); tick();
    chk("rst_sym_ready", sym_ready, 0);
    chk("rst_stage_run", stage_run, 0);
    chk("rst_stage_reset", stage_reset, 1);
    chk("rst_stage_symbols", stage_symbols, 0);
    chk("rst_rpt_valid", rpt_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    tick();
    chk("idle_stage_reset", stage_reset, 0);
    chk("idle_busy", busy, 0);
    sym_valid = 1'b1;
    #1;
    chk("idle_sym_ready", sym_ready, 0);
    chk("idle_stage_run", stage_run, 0);
    sym_valid = 1'b0;
    tick();

    // Five symbols, no reports
    r0 = run_cnt; c0 = clr_cnt; v0 = vld_cycles;
    pulse_start();
    #1;
    chk("clear_stage_reset", stage_reset, 1);
    chk("clear_busy", busy, 1);
    chk("clear_sym_ready", sym_ready, 0);
    stream(5, 8'h01, 1'b1);
    wait_done();
    chk("s1_runs", run_cnt - r0, 5);
    chk("s1_clear_cycles", clr_cnt - c0, 1);
    chk("s1_no_valid", vld_cycles - v0, 0);
    chk("s1_done_latency", done_cyc - lastacc_cyc, 2);
    chk("s1_hold_symbol", stage_symbols, 8'h05);
    chk("s1_idle_busy", busy, 0);

    // Two reports at offsets 2 and 4
    rmap[8'h12] = 28'h0000001;
    rmap[8'h14] = 28'h8000000;
    pop_q.delete();
    pulse_start();
    stream(5, 8'h10, 1'b1);
    wait_done();
    chk("s2_count", pop_q.size(), 2);
    chk("s2_e0", pop_q[0], {32'd2, 28'h0000001});
    chk("s2_e1", pop_q[1], {32'd4, 28'h8000000});

    // Backpressure: FIFO fills, sym_ready drops after 7 accepts
    rmap[8'h21] = 28'h0A5A5A5;
    rmap[8'h22] = 28'h0A5A5A5;
    rmap[8'h23] = 28'h0A5A5A5;
    pop_q.delete();
    rpt_ready = 1'b0;
    pulse_start();
    r0 = run_cnt;
    sym_valid = 1'b1; sym_data = 8'h21; sym_last = 1'b0;
    repeat (20) tick();
    #1;
    chk("s3_accepts", run_cnt - r0, 7);
    chk("s3_ready_low", sym_ready, 0);
    chk("s3_rpt_valid", rpt_valid, 1);
    chk("s3_head_offset", rpt_offset, 0);
    chk("s3_head_vector", rpt_vector, 28'h0A5A5A5);
    chk("s3_no_pops", pop_q.size(), 0);
    rpt_ready = 1'b1;
    stream(3, 8'h21, 1'b1);
    wait_done();
    chk("s3_count", pop_q.size(), 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("s3_e%0d", i), pop_q[i], {32'(i), 28'h0A5A5A5});

    // Back-to-back reports: push and pop coincide at count 1
    for (int i = 0; i < 4; i++) rmap[8'h40 + i] = 28'(i + 1);
    pop_q.delete();
    v0 = vld_cycles;
    pulse_start();
    stream(4, 8'h40, 1'b1);
    wait_done();
    chk("s4_count", pop_q.size(), 4);
    chk("s4_valid_cycles", vld_cycles - v0, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("s4_e%0d", i), pop_q[i], {32'(i), 28'(i + 1)});

    // Reset mid-stream with 3 entries queued
    rpt_ready = 1'b0;
    pulse_start();
    stream(3, 8'h21, 1'b0);
    repeat (3) tick();
    chk("s5_queued_valid", rpt_valid, 1);
    pulse_start();
    #1;
    chk("s5_start_ignored", stage_reset, 0);
    chk("s5_still_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("s5_rst_rpt_valid", rpt_valid, 0);
    chk("s5_rst_stage_reset", stage_reset, 1);
    chk("s5_rst_busy", busy, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("s5_after_rpt_valid", rpt_valid, 0);
    chk("s5_after_busy", busy, 0);
    d0 = done_cnt;
    repeat (5) tick();
    chk("s5_no_done", done_cnt - d0, 0);

    // Restart after reset: offsets begin at 0 again
    rmap[8'h30] = 28'h1234567;
    rpt_ready = 1'b1;
    pop_q.delete();
    pulse_start();
    stream(2, 8'h30, 1'b1);
    wait_done();
    chk("s5_restart_count", pop_q.size(), 1);
    chk("s5_restart_e0", pop_q[0], {32'd0, 28'h1234567});

`ifdef AUTOMATA_REPORT_COUNT_EN
    for (int i = 0; i < 6; i++) rmap[8'h50 + i] = 28'h0000003;
    pulse_start();
    stream(6, 8'h50, 1'b1);
    wait_done();
    chk("s6_count_at_done", done_rpt_count, 6);
    chk("s6_count_idle", rpt_count, 6);
    pulse_start();
    tick();
    chk("s6_count_cleared", rpt_count, 0);
    stream(1, 8'h60, 1'b1);
    wait_done();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/automata_stream_controller.md
AUTOMATA_STREAM_CONTROLLER -- requirements
Module: automata_stream_controller

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  NUM_REPORTS, 28, width of the stage report vector.
  SYM_W, 8, symbol width.
  OFF_W, 32, symbol-offset counter width.
  FIFO_DEPTH, 8, report FIFO entries (power of two, >=4).
  RPT_LAT, 1, cycles from `stage_run`/symbol to a valid report vector (1..4).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk, in, 1, single clock; all logic on its rising edge.
  reset, in, 1, synchronous, active-high reset.
  start, in, 1, one-cycle pulse that begins a stream.
  sym_valid, in, 1, input symbol valid.
  sym_ready, out, 1, input symbol accepted when sym_valid && sym_ready.
  sym_data, in, SYM_W, input symbol.
  sym_last, in, 1, final symbol of the stream.
  stage_run, out, 1, advances the automata stage one step.
  stage_reset, out, 1, clears automata state.
  stage_symbols, out, SYM_W, symbol presented to the stage.
  stage_reports, in, NUM_REPORTS, concatenated report wires from the stage.
  rpt_valid, out, 1, report entry valid.
  rpt_ready, in, 1, report entry consumed when rpt_valid && rpt_ready.
  rpt_offset, out, OFF_W, offset of the symbol that produced the report.
  rpt_vector, out, NUM_REPORTS, nonzero report vector.
  busy, out, 1, high in any state other than IDLE.
  done, out, 1, one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have the states IDLE, CLEAR, STREAM, DRAIN and FLUSH.
REQ-004 IDLE: start -> CLEAR. Other inputs are ignored and sym_ready=0.
REQ-005 CLEAR SHALL last exactly one cycle with stage_reset=1 and stage_run=0, and SHALL zero the offset counter; next state is STREAM.
REQ-006 STREAM: sym_ready SHALL be 1 iff FIFO free slots > RPT_LAT (counting entries already in flight), so the FIFO never overflows.
REQ-007 On each accepted symbol, stage_run=1 and stage_symbols=sym_data in the same cycle (combinational pass-through), and the offset increments by 1 (wraps modulo 2^OFF_W).
REQ-008 With no accepted symbol, stage_run SHALL be 0 and stage_symbols SHALL hold its last value.
REQ-009 A RPT_LAT-deep shift register SHALL carry {accepted, offset}. When its tail is accepted and stage_reports is nonzero, the block SHALL push {offset, stage_reports} into the FIFO. An all-zero vector is never pushed.
REQ-010 An accepted symbol with sym_last=1 -> DRAIN. DRAIN SHALL wait until the shift register is empty (RPT_LAT cycles), then go to FLUSH.
REQ-011 FLUSH: when the FIFO is empty, assert done for one cycle -> IDLE.
REQ-012 rpt_valid SHALL equal FIFO non-empty. The output SHALL be first-word fall-through, and data SHALL be held stable while rpt_valid && !rpt_ready.
REQ-013 A push and a pop in the same cycle SHALL both take effect, leaving the count unchanged; this includes a pop of the last entry while a push lands.
REQ-014 A start pulse outside IDLE SHALL be ignored.

Reset
REQ-015 reset SHALL take priority over all inputs. It forces IDLE, empties the FIFO and shift register, and sets offset=0.
REQ-016 Output values during and after reset SHALL be: sym_ready=0, stage_run=0, stage_reset=1 while reset is high, stage_symbols=0, rpt_valid=0, busy=0, done=0.
REQ-017 reset asserted mid-stream SHALL discard all pending reports without emitting a done pulse.

Configuration
REQ-018 With AUTOMATA_REPORT_COUNT_EN defined, the block SHALL add output rpt_count[OFF_W]. rpt_count is cleared in CLEAR, increments once per FIFO push, and saturates at all-ones.
REQ-019 Without AUTOMATA_REPORT_COUNT_EN, the rpt_count port and its logic SHALL be absent.

Structure
REQ-020 A shared package automata_ctrl_pkg SHALL hold the FSM state encoding, the report-entry typedef {offset, vector}, and the default parameter constants.
REQ-021 The FIFO SHALL be a sub-module named automata_report_fifo, parameterized by width and depth, exposing push, pop, full, empty and free-count.

Verification
REQ-022 Directed scenarios (stimulus -> required response):
  - Stream of 5 symbols, no reports -> stage_reset for 1 cycle, 5 stage_run pulses, rpt_valid never asserted, done 1+RPT_LAT cycles after the last symbol, offset restarts at 0 on the next stream.
  - stage_reports=28'h0000001 for offset 2 and 28'h8000000 for offset 4 -> exactly two entries, (2, 28'h0000001) then (4, 28'h8000000).
  - rpt_ready=0, FIFO_DEPTH=8, RPT_LAT=1, reports on every symbol -> sym_ready drops after 7 accepts, no entry is lost, streaming resumes when rpt_ready=1.
  - Simultaneous push and pop with count=1 -> count stays 1 and ordering is preserved.
  - reset asserted in STREAM with 3 entries queued -> next cycle rpt_valid=0, busy=0, no done pulse.
  - AUTOMATA_REPORT_COUNT_EN defined, 6 reporting symbols -> rpt_count=6 at done, cleared to 0 at the next start.
